dds_envelope: RTL

ADSR amplitude envelope stage placed directly downstream of the dds waveform transforms (dds2tria, dds2saw, dds2revsaw, dds2meandr, dds2pwm). It takes one unsigned WIDTH-bit waveform sample per clock and multiplies it by an envelope level. A gate input drives that level through attack, decay, sustain and release. The output is an amplitude-shaped sample for the mixer or DAC stage.

---
 rtl/dds_pkg.sv | 27 ++
 rtl/dds_prescaler.sv | 41 ++++
 rtl/dds_envelope.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/dds_pkg.sv
// Shared definitions for the dds envelope stage: ADSR state encoding and
// the full-scale level helper.
package dds_pkg;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_ATTACK  = 3'd1;
  localparam logic [2:0] ST_DECAY   = 3'd2;
  localparam logic [2:0] ST_SUSTAIN = 3'd3;
  localparam logic [2:0] ST_RELEASE = 3'd4;

  typedef enum logic [2:0] {
    ENV_IDLE    = ST_IDLE,
    ENV_ATTACK  = ST_ATTACK,
    ENV_DECAY   = ST_DECAY,
    ENV_SUSTAIN = ST_SUSTAIN,
    ENV_RELEASE = ST_RELEASE
  } env_state_t;

  function automatic logic [31:0] env_max(input int unsigned env_width);
    if (env_width >= 32'd32) begin
      return 32'hFFFF_FFFF;
    end else begin
      return (32'd1 << env_width) - 32'd1;
    end
  endfunction

endpackage

// File: rtl/dds_prescaler.sv
// Free-running 0..TICK_DIV-1 counter; tick is high while the count sits at
// its last value.
module dds_prescaler #(
  parameter int TICK_DIV = 1024
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int CW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] count_r;
  logic [CW-1:0] count_nx_s;
  logic          tick_r;

  // Wrap the counter at its last value
  always_comb begin
    count_nx_s = count_r;
    if (count_r == LAST) begin
      count_nx_s = {CW{1'b0}};
    end else begin
      count_nx_s = count_r + CW'(1);
    end
  end

  // Count register; tick is a registered decode of the upcoming count
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_r <= {CW{1'b0}};
      tick_r  <= 1'b0;
    end else begin
      count_r <= count_nx_s;
      tick_r  <= (count_nx_s == LAST);
    end
  end

  assign tick = tick_r;

endmodule

// File: rtl/dds_envelope.sv
// ADSR amplitude envelope: gate-driven level sequencer followed by a
// one-stage unsigned multiply that scales the incoming waveform sample.
module dds_envelope
  import dds_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int ENV_WIDTH = 16,
  parameter int TICK_DIV  = 1024
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 gate,
  input  logic [ENV_WIDTH-1:0] attack_rate,
  input  logic [ENV_WIDTH-1:0] decay_rate,
  input  logic [ENV_WIDTH-1:0] sustain_level,
  input  logic [ENV_WIDTH-1:0] release_rate,
  input  logic [WIDTH-1:0]     signal_in,
  output logic [WIDTH-1:0]     signal_out,
  output logic [ENV_WIDTH-1:0] env_level,
  output logic [2:0]           env_state,
  output logic                 busy
);

  localparam int PW = WIDTH + ENV_WIDTH;
  localparam logic [ENV_WIDTH-1:0] ENV_MAX = ENV_WIDTH'(env_max(ENV_WIDTH));
  localparam logic [ENV_WIDTH-1:0] ZERO    = {ENV_WIDTH{1'b0}};

  logic                 tick_s;
  env_state_t           state_r;
  env_state_t           state_nx_s;
  logic [ENV_WIDTH-1:0] level_r;
  logic [ENV_WIDTH-1:0] level_nx_s;
  logic [ENV_WIDTH:0]   attack_sum_s;
  logic [ENV_WIDTH:0]   decay_floor_s;
  logic [PW-1:0]        product_s;
  logic [WIDTH-1:0]     out_nx_s;
  logic [WIDTH-1:0]     out_r;
  logic                 busy_r;

  dds_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .tick  (tick_s)
  );

  // Overflow-free sums and the scaling product
  always_comb begin
    attack_sum_s  = {1'b0, level_r} + {1'b0, attack_rate};
    decay_floor_s = {1'b0, sustain_level} + {1'b0, decay_rate};
    product_s     = PW'(signal_in) * PW'(level_r);
    out_nx_s      = WIDTH'(product_s >> ENV_WIDTH);
  end

  // Next state and next level; gate edges win over tick-driven steps
  always_comb begin
    state_nx_s = state_r;
    level_nx_s = level_r;
    case (state_r)
      ENV_IDLE: begin
        level_nx_s = ZERO;
        if (gate) begin
          state_nx_s = ENV_ATTACK;
        end else begin
          state_nx_s = ENV_IDLE;
        end
      end
      ENV_ATTACK: begin
        if (!gate) begin
          state_nx_s = ENV_RELEASE;
        end else if (tick_s) begin
          if ((attack_rate == ZERO) || (attack_sum_s >= {1'b0, ENV_MAX})) begin
            level_nx_s = ENV_MAX;
            state_nx_s = ENV_DECAY;
          end else begin
            level_nx_s = attack_sum_s[ENV_WIDTH-1:0];
          end
        end else begin
          state_nx_s = ENV_ATTACK;
        end
      end
      ENV_DECAY: begin
        if (!gate) begin
          state_nx_s = ENV_RELEASE;
        end else if (tick_s) begin
          // Landing on sustain also covers a sustain above the current level
          if ((decay_rate == ZERO) || ({1'b0, level_r} <= decay_floor_s)) begin
            level_nx_s = sustain_level;
            state_nx_s = ENV_SUSTAIN;
          end else begin
            level_nx_s = level_r - decay_rate;
          end
        end else begin
          state_nx_s = ENV_DECAY;
        end
      end
      ENV_SUSTAIN: begin
        if (!gate) begin
          state_nx_s = ENV_RELEASE;
        end else if (tick_s) begin
          level_nx_s = sustain_level;
        end else begin
          state_nx_s = ENV_SUSTAIN;
        end
      end
      ENV_RELEASE: begin
        if (gate) begin
          state_nx_s = ENV_ATTACK;
        end else if (tick_s) begin
          if ((release_rate == ZERO) || (level_r <= release_rate)) begin
            level_nx_s = ZERO;
            state_nx_s = ENV_IDLE;
          end else begin
            level_nx_s = level_r - release_rate;
          end
        end else begin
          state_nx_s = ENV_RELEASE;
        end
      end
      default: begin
        state_nx_s = ENV_IDLE;
        level_nx_s = ZERO;
      end
    endcase
  end

  // Sequencer registers; busy tracks the state being entered
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= ENV_IDLE;
      level_r <= ZERO;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_nx_s;
      level_r <= level_nx_s;
      busy_r  <= (state_nx_s != ENV_IDLE);
    end
  end

  // Scaled sample register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_r <= {WIDTH{1'b0}};
    end else begin
      out_r <= out_nx_s;
    end
  end

  assign signal_out = out_r;
  assign env_level  = level_r;
  assign env_state  = state_r;
  assign busy       = busy_r;

endmodule
